// File: rtl/lisp.sv
// Shared definitions for the evaluator datapath: object tags, object sizes
// and the allocator state encoding.
package lisp;

  localparam int addr_width = 16;
  localparam int data_width = 16;

  localparam logic [15:0] TYPE_NIL       = 16'h0000;
  localparam logic [15:0] TYPE_NUMBER    = 16'h0001;
  localparam logic [15:0] TYPE_CONS      = 16'h0002;
  localparam logic [15:0] TYPE_FUNC_PRIM = 16'h0003;

  localparam logic [1:0] OBJ_SIZE_NUMBER    = 2'd2;
  localparam logic [1:0] OBJ_SIZE_CONS      = 2'd3;
  localparam logic [1:0] OBJ_SIZE_FUNC_PRIM = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_WRITE,
    ST_DONE,
    ST_FULL
  } alloc_state_t;

  // Size 0 marks a tag the allocator does not know how to lay out.
  function automatic logic [1:0] obj_size(input logic [15:0] tag);
    case (tag)
      TYPE_NUMBER:    obj_size = OBJ_SIZE_NUMBER;
      TYPE_CONS:      obj_size = OBJ_SIZE_CONS;
      TYPE_FUNC_PRIM: obj_size = OBJ_SIZE_FUNC_PRIM;
      default:        obj_size = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/heap_alloc.sv
// Bump-pointer allocator: latches a tagged object, writes it word by word
// through the arbitrated heap write port and returns its base address.
module heap_alloc
  import lisp::*;
#(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    DATA_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] HEAP_BASE  = 16'h0100,
  parameter logic [ADDR_WIDTH-1:0] HEAP_LIMIT = 16'hFFFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alloc_req,
  output logic                  alloc_ready,
  input  logic [DATA_WIDTH-1:0] alloc_tag,
  input  logic [DATA_WIDTH-1:0] alloc_w1,
  input  logic [DATA_WIDTH-1:0] alloc_w2,
  input  logic                  heap_clear,
  output logic                  alloc_done,
  output logic                  alloc_err,
  output logic [ADDR_WIDTH-1:0] alloc_addr,
  output logic                  heap_full,
  output logic [ADDR_WIDTH-1:0] free_ptr,
  output logic                  mem_req,
  input  logic                  mem_grant,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata
);

  alloc_state_t          r_state;
  alloc_state_t          w_next_state;
  logic [DATA_WIDTH-1:0] r_tag;
  logic [DATA_WIDTH-1:0] r_w1;
  logic [DATA_WIDTH-1:0] r_w2;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [1:0]            r_size;
  logic [1:0]            r_k;
  logic [ADDR_WIDTH-1:0] r_free_ptr;
  logic                  r_heap_full;
  logic                  r_full_pulse;
  logic [ADDR_WIDTH:0]   w_last;

  // One extra bit so an object running past the top of memory cannot wrap.
  assign w_last = {1'b0, r_base} + {{(ADDR_WIDTH-1){1'b0}}, r_size} - (ADDR_WIDTH+1)'(1);

  assign free_ptr  = r_free_ptr;
  assign heap_full = r_heap_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    alloc_ready  = 1'b0;
    alloc_done   = 1'b0;
    alloc_err    = 1'b0;
    alloc_addr   = '0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    case (r_state)
      ST_IDLE: begin
        alloc_ready = !heap_clear;
        if (alloc_req && !heap_clear) w_next_state = ST_CHECK;
      end
      ST_CHECK: begin
        if (r_size == 2'd0)                      w_next_state = ST_DONE;
        else if (w_last > {1'b0, HEAP_LIMIT})    w_next_state = ST_FULL;
        else                                     w_next_state = ST_WRITE;
      end
      ST_WRITE: begin
        mem_req  = 1'b1;
        mem_addr = r_base + ADDR_WIDTH'(r_k);
        case (r_k)
          2'd0:    mem_wdata = r_tag;
          2'd1:    mem_wdata = r_w1;
          default: mem_wdata = r_w2;
        endcase
        // A withheld grant pauses the burst in place; it never restarts.
        if (mem_grant) begin
          mem_we = 1'b1;
          if (r_k == r_size - 2'd1) w_next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        alloc_done   = 1'b1;
        alloc_err    = (r_size == 2'd0);
        alloc_addr   = r_base;
        w_next_state = ST_IDLE;
      end
      ST_FULL: begin
        alloc_done = r_full_pulse;
        if (heap_clear) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tag        <= '0;
      r_w1         <= '0;
      r_w2         <= '0;
      r_base       <= '0;
      r_size       <= '0;
      r_k          <= '0;
      r_free_ptr   <= HEAP_BASE;
      r_heap_full  <= 1'b0;
      r_full_pulse <= 1'b0;
    end else begin
      r_full_pulse <= (r_state == ST_CHECK) && (w_next_state == ST_FULL);
      case (r_state)
        ST_IDLE: begin
          if (heap_clear) begin
            r_free_ptr  <= HEAP_BASE;
            r_heap_full <= 1'b0;
          end else if (alloc_req) begin
            r_tag  <= alloc_tag;
            r_w1   <= alloc_w1;
            r_w2   <= alloc_w2;
            r_base <= r_free_ptr;
            r_size <= obj_size(16'(alloc_tag));
            r_k    <= 2'd0;
          end
        end
        ST_CHECK: begin
          if (w_next_state == ST_FULL) r_heap_full <= 1'b1;
        end
        ST_WRITE: begin
          if (mem_grant) r_k <= r_k + 2'd1;
        end
        ST_DONE: begin
          if (r_size != 2'd0) r_free_ptr <= r_base + ADDR_WIDTH'(r_size);
        end
        ST_FULL: begin
          if (heap_clear) begin
            r_free_ptr  <= HEAP_BASE;
            r_heap_full <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_heap_alloc.sv
// Bench for heap_alloc: a scoreboard of expected heap writes and completions,
// a vector table of allocations, and hand-built grant/reset/clear sequences.
module tb_heap_alloc;
  import lisp::*;

  localparam logic [15:0] BASE  = 16'h0100;
  localparam logic [15:0] LIMIT = 16'h0108;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alloc_req = 1'b0;
  logic        alloc_ready;
  logic [15:0] alloc_tag = '0;
  logic [15:0] alloc_w1 = '0;
  logic [15:0] alloc_w2 = '0;
  logic        heap_clear = 1'b0;
  logic        alloc_done;
  logic        alloc_err;
  logic [15:0] alloc_addr;
  logic        heap_full;
  logic [15:0] free_ptr;
  logic        mem_req;
  logic        mem_grant = 1'b1;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;

  heap_alloc #(
    .ADDR_WIDTH(16), .DATA_WIDTH(16), .HEAP_BASE(BASE), .HEAP_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst(rst),
    .alloc_req(alloc_req), .alloc_ready(alloc_ready),
    .alloc_tag(alloc_tag), .alloc_w1(alloc_w1), .alloc_w2(alloc_w2),
    .heap_clear(heap_clear),
    .alloc_done(alloc_done), .alloc_err(alloc_err), .alloc_addr(alloc_addr),
    .heap_full(heap_full), .free_ptr(free_ptr),
    .mem_req(mem_req), .mem_grant(mem_grant), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct { logic [15:0] addr; logic [15:0] data; } wr_t;
  typedef struct { logic [15:0] addr; logic err; } done_t;
  typedef struct {
    logic [15:0] tag; logic [15:0] w1; logic [15:0] w2;
    logic err; logic full; logic [15:0] addr; logic [15:0] free; int lat;
  } vec_t;

  wr_t   wr_q[$];
  done_t done_q[$];
  vec_t  vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic fail(input string name, input logic [31:0] act);
    n_checks++;
    $display("FAIL %s: got %h, expected nothing", name, act);
  endtask

  // Monitor: every write and completion must match the head of its queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_we) begin
        if (wr_q.size() == 0) fail("unexpected_write", {mem_addr, mem_wdata});
        else begin
          wr_t e;
          e = wr_q.pop_front();
          check("write_addr", mem_addr, e.addr);
          check("write_data", mem_wdata, e.data);
          $display("write  addr=%h data=%h", mem_addr, mem_wdata);
        end
        check("we_implies_req", mem_req, 1);
      end
      if (alloc_done) begin
        if (done_q.size() == 0) fail("unexpected_done", alloc_addr);
        else begin
          done_t d;
          d = done_q.pop_front();
          check("done_addr", alloc_addr, d.addr);
          check("done_err", alloc_err, d.err);
          $display("done   addr=%h err=%b", alloc_addr, alloc_err);
        end
      end
    end
  end

  task automatic do_alloc(input logic [15:0] tag, input logic [15:0] w1, input logic [15:0] w2,
                          input logic err, input logic full, input logic [15:0] addr,
                          input logic [15:0] free, input int exp_lat);
    int size;
    int lat;
    bit accepted;
    bit got;
    size = (err || full) ? 0 : ((tag == TYPE_CONS) ? 3 : 2);
    for (int i = 0; i < size; i++)
      wr_q.push_back('{addr + 16'(i), (i == 0) ? tag : ((i == 1) ? w1 : w2)});
    done_q.push_back('{full ? 16'h0000 : addr, err});
    @(negedge clk);
    alloc_tag = tag; alloc_w1 = w1; alloc_w2 = w2; alloc_req = 1'b1;
    accepted = 0;
    for (int i = 0; i < 20; i++) begin
      if (alloc_ready) begin
        @(posedge clk);
        accepted = 1;
        break;
      end
      @(negedge clk);
    end
    #1 alloc_req = 1'b0;
    if (!accepted) begin
      fail("accept_timeout", tag);
      return;
    end
    lat = 0; got = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (alloc_done) begin got = 1; break; end
    end
    if (!got) fail("done_timeout", tag);
    else if (exp_lat != 0) check("latency", lat, exp_lat);
    @(negedge clk);
    check("free_ptr", free_ptr, free);
    check("heap_full", heap_full, full);
    check("ready_after", alloc_ready, !full);
    $display("alloc  tag=%h lat=%0d free=%h", tag, lat, free_ptr);
  endtask

  task automatic clear_heap();
    @(negedge clk);
    heap_clear = 1'b1;
    @(posedge clk);
    #1 heap_clear = 1'b0;
    @(negedge clk);
    check("clear_free", free_ptr, BASE);
    check("clear_full", heap_full, 0);
    check("clear_ready", alloc_ready, 1);
    $display("clear  free=%h", free_ptr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    vecs[0] = '{TYPE_NUMBER,    16'h0042, 16'h5555, 1'b0, 1'b0, 16'h0100, 16'h0102, 4};
    vecs[1] = '{TYPE_CONS,      16'h0120, 16'h0000, 1'b0, 1'b0, 16'h0102, 16'h0105, 5};
    vecs[2] = '{16'hBEEF,       16'h0001, 16'h0002, 1'b1, 1'b0, 16'h0105, 16'h0105, 2};
    vecs[3] = '{TYPE_FUNC_PRIM, 16'h0007, 16'hAAAA, 1'b0, 1'b0, 16'h0105, 16'h0107, 4};
    vecs[4] = '{TYPE_NUMBER,    16'h1234, 16'h0000, 1'b0, 1'b0, 16'h0107, 16'h0109, 4};
    vecs[5] = '{TYPE_CONS,      16'h0001, 16'h0002, 1'b0, 1'b1, 16'h0000, 16'h0109, 2};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", alloc_ready, 1);
    check("rst_free", free_ptr, BASE);
    check("rst_done", alloc_done, 0);
    check("rst_req", mem_req, 0);
    check("rst_we", mem_we, 0);
    check("rst_full", heap_full, 0);
    rst = 1'b0;

    // Single cons with grant high
    do_alloc(TYPE_CONS, 16'h0120, 16'h0000, 1'b0, 1'b0, 16'h0100, 16'h0103, 5);
    clear_heap();

    // Vector table: mixed objects, bad tag, exact fit, then overflow
    foreach (vecs[i])
      do_alloc(vecs[i].tag, vecs[i].w1, vecs[i].w2, vecs[i].err, vecs[i].full,
               vecs[i].addr, vecs[i].free, vecs[i].lat);
    repeat (2) @(negedge clk);
    check("full_sticky", heap_full, 1);
    check("full_not_ready", alloc_ready, 0);
    clear_heap();

    // Grant withheld for two cycles after the first word
    fork
      do_alloc(TYPE_CONS, 16'h0abc, 16'h0def, 1'b0, 1'b0, 16'h0100, 16'h0103, 7);
      begin
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          if (mem_we) break;
        end
        @(posedge clk);
        #1 mem_grant = 1'b0;
        repeat (2) begin
          @(negedge clk);
          check("gap_no_we", mem_we, 0);
          check("gap_req_held", mem_req, 1);
        end
        @(posedge clk);
        #1 mem_grant = 1'b1;
      end
    join
    clear_heap();

    // Reset during the burst after word 1 has been written
    wr_q.push_back('{16'h0100, TYPE_CONS});
    wr_q.push_back('{16'h0101, 16'h0077});
    @(negedge clk);
    alloc_tag = TYPE_CONS; alloc_w1 = 16'h0077; alloc_w2 = 16'h0088; alloc_req = 1'b1;
    @(posedge clk);
    #1 alloc_req = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_we) cnt++;
      if (cnt == 2) break;
    end
    check("burst_words_before_rst", cnt, 2);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_async_we", mem_we, 0);
    check("rst_async_req", mem_req, 0);
    @(negedge clk);
    check("rst_mid_free", free_ptr, BASE);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_ready", alloc_ready, 1);
    check("rst_mid_queue", wr_q.size(), 0);
    $display("reset  mid-burst free=%h", free_ptr);

    // Clear and request together in IDLE: request is dropped
    @(negedge clk);
    alloc_tag = TYPE_CONS; alloc_req = 1'b1; heap_clear = 1'b1;
    #1 check("clear_blocks_ready", alloc_ready, 0);
    @(posedge clk);
    #1 begin alloc_req = 1'b0; heap_clear = 1'b0; end
    repeat (4) begin
      @(negedge clk);
      check("clear_req_no_mem", mem_req, 0);
    end
    check("clear_req_free", free_ptr, BASE);
    check("clear_req_ready", alloc_ready, 1);
    $display("clear+req  ready=%b free=%h", alloc_ready, free_ptr);

    check("wr_q_empty", wr_q.size(), 0);
    check("done_q_empty", done_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
